// File: rtl/uart_tx_datapath.sv
// ---------------------------------------------------------------------------
// uart_tx_datapath
//
// Serial-line datapath for the UART transmitter. It sits under the TX control
// FSM. It captures the parallel word and its parity bit when the FSM is idle.
// It walks the captured word LSB-first while the FSM is in its data state and
// tells the FSM when the last data bit is on the mux. All line values
// (start/data/parity/stop) go through one output flop, so TX_OUT is
// glitch-free and every bit period has the same one-cycle lag from mux_sel.
//
// Ports
//   clk          system / UART TX clock, rising edge
//   ARSTn        asynchronous active-low reset
//   P_DATA       parallel word to send
//   DATA_VALID   P_DATA valid this cycle (also seen by the FSM)
//   PAR_TYP      0 = even parity, 1 = odd parity; sampled with P_DATA
//   busy         FSM busy flag, low only while the FSM is idle
//   serial_en    FSM shift enable (advances the bit index in the data state)
//   mux_sel      line select: 00 start, 01 data, 10 parity, 11 idle/stop
//   serial_done  combinational: last data bit is being selected this cycle
//   TX_OUT       registered serial line, idles high
//   drop         one-cycle pulse: a word arrived while busy and was discarded
// ---------------------------------------------------------------------------
module uart_tx_datapath #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  ARSTn,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_TYP,
    input  logic                  busy,
    input  logic                  serial_en,
    input  logic [1:0]            mux_sel,
    output logic                  serial_done,
    output logic                  TX_OUT,
    output logic                  drop
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        SEL_START  = 2'b00,
        SEL_DATA   = 2'b01,
        SEL_PARITY = 2'b10,
        SEL_IDLE   = 2'b11
    } line_sel_e;

    line_sel_e             line_sel;
    logic                  capture;
    logic                  reject;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_q;
    logic [CNT_W-1:0]      cnt;
    logic                  ser_bit;
    logic                  tx_next;

    assign line_sel = line_sel_e'(mux_sel);

    // A word is accepted only while the FSM is idle. The same DATA_VALID that
    // the FSM sees on the cycle busy drops is therefore a capture, not a drop.
    assign capture = DATA_VALID & ~busy;
    assign reject  = DATA_VALID &  busy;

    // Parity is computed at capture time so the parity slot needs no logic
    // in the line path.
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else if (capture) begin
            data_q <= P_DATA;
            par_q  <= (^P_DATA) ^ PAR_TYP;
        end
    end

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            drop <= 1'b0;
        end else begin
            drop <= reject;
        end
    end

    // Bit index. It is cleared whenever the line is not in the data slot, so
    // an enable seen during the start slot never pre-advances it. The FSM
    // stops enabling at the last bit, so the index never wraps inside a frame.
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            cnt <= '0;
        end else if (line_sel != SEL_DATA) begin
            cnt <= '0;
        end else if (serial_en) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // The word is indexed, not shifted, so data_q still holds the word after
    // the frame has been sent.
    assign ser_bit     = data_q[cnt];
    assign serial_done = (line_sel == SEL_DATA) && (cnt == CNT_LAST);

    always_comb begin
        tx_next = 1'b1;
        case (line_sel)
            SEL_START:  tx_next = 1'b0;
            SEL_DATA:   tx_next = ser_bit;
            SEL_PARITY: tx_next = par_q;
            SEL_IDLE:   tx_next = 1'b1;
            default:    tx_next = 1'b1;
        endcase
    end

    // The line resets high, so an abort mid-frame returns the line to idle
    // immediately.
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            TX_OUT <= 1'b1;
        end else begin
            TX_OUT <= tx_next;
        end
    end

endmodule
